quadrature_phase_lut: RTL and testbench

Parametrised full-wave two-phase current reference generator for the microstepper. It accepts a full-circle phase index and an amplitude, and returns scaled cosine (coil A) and sine (coil B) magnitudes with polarity bits for the H-bridge drivers. All four quadrants and both coils are served from a single-port, registered quarter-wave cosine table; a small FSM sequences the table reads and the scaling step.

---
 rtl/quadrature_phase_lut.sv | 142 ++++++++++++++
 tb/tb_quadrature_phase_lut.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_phase_lut.sv
// Two-phase microstep current reference: folds a full-circle phase onto a
// quarter-wave cosine table and scales both coil magnitudes by an amplitude.
module quadrature_phase_lut #(
    parameter int INDEX_BITS = 6,
    parameter int VALUE_BITS = 8,
    parameter int AMP_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS+1:0] phase,
    input  logic [AMP_BITS-1:0]   amplitude,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VALUE_BITS-1:0] cos_mag,
    output logic                  cos_neg,
    output logic [VALUE_BITS-1:0] sin_mag,
    output logic                  sin_neg
);

    localparam int     DEPTH      = 1 << INDEX_BITS;
    localparam int     FRAC       = 28;
    localparam longint PI_Q       = 64'sd843314857;
    localparam longint ONE_Q      = longint'(1) << FRAC;
    localparam longint HALF_Q     = longint'(1) << (FRAC - 1);
    localparam longint FULL_SCALE = (longint'(1) << VALUE_BITS) - 1;

    // Integer Taylor series keeps the table build free of real arithmetic.
    function automatic logic [DEPTH*VALUE_BITS-1:0] build_table();
        logic [DEPTH*VALUE_BITS-1:0] tbl;
        longint x, x2, term, acc, val;
        tbl = '0;
        for (int k = 0; k < DEPTH; k++) begin
            x    = (longint'(k) * PI_Q) / longint'(2 * DEPTH);
            x2   = (x * x) >>> FRAC;
            term = ONE_Q;
            acc  = ONE_Q;
            for (int n = 1; n <= 12; n++) begin
                term = -(((term * x2) >>> FRAC) / longint'((2 * n - 1) * (2 * n)));
                acc  = acc + term;
            end
            val = (FULL_SCALE * acc + HALF_Q) >>> FRAC;
            tbl[k*VALUE_BITS +: VALUE_BITS] = val[VALUE_BITS-1:0];
        end
        return tbl;
    endfunction

    localparam logic [DEPTH*VALUE_BITS-1:0] LUT = build_table();

    function automatic logic [VALUE_BITS-1:0] scale_mag(
        input logic [VALUE_BITS-1:0] mag,
        input logic [AMP_BITS-1:0]   amp
    );
        logic [VALUE_BITS+AMP_BITS-1:0] prod;
        prod = {{AMP_BITS{1'b0}}, mag} * {{VALUE_BITS{1'b0}}, amp};
        return VALUE_BITS'(prod >> AMP_BITS);
    endfunction

    function automatic logic polarity(
        input logic                  neg,
        input logic [VALUE_BITS-1:0] mag,
        input logic [AMP_BITS-1:0]   amp
    );
        return neg && (mag != '0) && (amp != '0);
    endfunction

    typedef enum logic [2:0] {IDLE, RD_COS, RD_SIN, SCALE, OUT} state_t;

    state_t                  state;
    logic [INDEX_BITS+1:0]   phase_p0;
    logic [AMP_BITS-1:0]     amp_p0;
    logic [VALUE_BITS-1:0]   rom_q_p1;
    logic [VALUE_BITS-1:0]   cos_raw_p1;
    logic [1:0]              quad;
    logic [INDEX_BITS-1:0]   offset;
    logic [INDEX_BITS-1:0]   comp_idx;
    logic [INDEX_BITS-1:0]   cos_addr;
    logic [INDEX_BITS-1:0]   sin_addr;
    logic [INDEX_BITS-1:0]   rom_addr;
    logic                    cos_at_d;
    logic                    sin_at_d;
    logic [VALUE_BITS-1:0]   sin_raw;

    assign quad     = phase_p0[INDEX_BITS+1 -: 2];
    assign offset   = phase_p0[INDEX_BITS-1:0];
    // D - i modulo DEPTH; the i == 0 case is the C(DEPTH) = 0 bypass.
    assign comp_idx = INDEX_BITS'(0) - offset;
    assign cos_addr = quad[0] ? comp_idx : offset;
    assign sin_addr = quad[0] ? offset : comp_idx;
    assign cos_at_d = quad[0] && (offset == '0);
    assign sin_at_d = !quad[0] && (offset == '0);
    assign rom_addr = (state == RD_SIN) ? sin_addr : cos_addr;
    assign sin_raw  = sin_at_d ? '0 : rom_q_p1;
    assign in_ready = (state == IDLE) && !reset;

    // Stage p0 capture, p1 single-port registered table read.
    always_ff @(posedge clk) begin
        rom_q_p1 <= LUT[int'(rom_addr) * VALUE_BITS +: VALUE_BITS];
        if (state == IDLE && in_valid) begin
            phase_p0 <= phase;
            amp_p0   <= amplitude;
        end
        if (state == RD_SIN) begin
            cos_raw_p1 <= cos_at_d ? '0 : rom_q_p1;
        end
    end

    // Stage p2: sequencing, scaling and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cos_mag   <= '0;
            cos_neg   <= 1'b0;
            sin_mag   <= '0;
            sin_neg   <= 1'b0;
        end else begin
            case (state)
                IDLE:   if (in_valid) state <= RD_COS;
                RD_COS: state <= RD_SIN;
                RD_SIN: state <= SCALE;
                SCALE: begin
                    cos_mag   <= scale_mag(cos_raw_p1, amp_p0);
                    cos_neg   <= polarity(quad[0] ^ quad[1], cos_raw_p1, amp_p0);
                    sin_mag   <= scale_mag(sin_raw, amp_p0);
                    sin_neg   <= polarity(quad[1], sin_raw, amp_p0);
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quadrature_phase_lut.sv
// Bench for quadrature_phase_lut: directed quadrant vectors, backpressure,
// throughput, a full phase sweep and mid-transaction reset against a trig model.
module tb_quadrature_phase_lut;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] phase = '0;
    logic [7:0] amplitude = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] cos_mag;
    logic       cos_neg;
    logic [7:0] sin_mag;
    logic       sin_neg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quadrature_phase_lut dut (
        .clk(clk), .reset(reset), .phase(phase), .amplitude(amplitude),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .cos_mag(cos_mag), .cos_neg(cos_neg),
        .sin_mag(sin_mag), .sin_neg(sin_neg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: ideal cos/sin of the full-circle angle, quantised to 8 bits.
    function automatic logic [17:0] model(input int ph, input int amp);
        real th, c, s;
        int cu, su, cm, sm;
        logic cn, sn;
        th = 2.0 * 3.14159265358979 * real'(ph) / 256.0;
        c  = $cos(th);
        s  = $sin(th);
        cu = $rtoi(255.0 * ((c < 0.0) ? -c : c) + 0.5);
        su = $rtoi(255.0 * ((s < 0.0) ? -s : s) + 0.5);
        cm = (cu * amp) >> 8;
        sm = (su * amp) >> 8;
        cn = (c < 0.0) && (cu != 0) && (amp != 0);
        sn = (s < 0.0) && (su != 0) && (amp != 0);
        return {cm[7:0], cn, sm[7:0], sn};
    endfunction

    task automatic issue(input int ph, input int amp, output int lat);
        phase     = 8'(ph);
        amplitude = 8'(amp);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready/out_valid=%b required 00", {in_ready, out_valid});
        end
        checks++;
        if ({cos_mag, cos_neg, sin_mag, sin_neg} !== 18'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {cos_mag, cos_neg, sin_mag, sin_neg});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        int ph[4]  = '{0, 64, 160, 235};
        int amp[4] = '{255, 255, 128, 255};
        int cm[4]  = '{254, 0, 90, 221};
        int cn[4]  = '{0, 0, 1, 0};
        int sm[4]  = '{0, 254, 90, 125};
        int sn[4]  = '{0, 0, 1, 1};
        int lat;
        logic [17:0] exp_v;
        for (int k = 0; k < 4; k++) begin
            issue(ph[k], amp[k], lat);
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL latency ph=%0d: edges after accept=%0d required 3", ph[k], lat);
            end
            exp_v = {8'(cm[k]), 1'(cn[k]), 8'(sm[k]), 1'(sn[k])};
            checks++;
            if ({cos_mag, cos_neg, sin_mag, sin_neg} !== exp_v) begin
                errors++;
                $display("FAIL directed ph=%0d: got cm=%0d cn=%b sm=%0d sn=%b required cm=%0d cn=%0d sm=%0d sn=%0d",
                         ph[k], cos_mag, cos_neg, sin_mag, sin_neg, cm[k], cn[k], sm[k], sn[k]);
            end
            release_out();
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL post_handshake ph=%0d: out_valid/in_ready=%b required 01",
                         ph[k], {out_valid, in_ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [17:0] exp_v;
        exp_v = model(200, 77);
        issue(200, 77, lat);
        for (int c = 0; c < 10; c++) begin
            in_valid  = 1'($urandom_range(1));
            phase     = 8'($urandom);
            amplitude = 8'($urandom);
            tick();
            checks++;
            if ({out_valid, in_ready} !== 2'b10 ||
                {cos_mag, cos_neg, sin_mag, sin_neg} !== exp_v) begin
                errors++;
                $display("FAIL hold cycle %0d: vld/rdy=%b data=%h required 10 %h",
                         c, {out_valid, in_ready}, {cos_mag, cos_neg, sin_mag, sin_neg}, exp_v);
            end
        end
        in_valid  = 1'b1;
        phase     = 8'd45;
        amplitude = 8'd200;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01 ||
            {cos_mag, cos_neg, sin_mag, sin_neg} !== exp_v) begin
            errors++;
            $display("FAIL release: vld/rdy=%b data=%h required 01 %h",
                     {out_valid, in_ready}, {cos_mag, cos_neg, sin_mag, sin_neg}, exp_v);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL deferred_accept: in_ready=%b required 0", in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        exp_v = model(45, 200);
        checks++;
        if (lat != 3 || {cos_mag, cos_neg, sin_mag, sin_neg} !== exp_v) begin
            errors++;
            $display("FAIL deferred_result: lat=%0d data=%h required 3 %h",
                     lat, {cos_mag, cos_neg, sin_mag, sin_neg}, exp_v);
        end
        release_out();
    endtask

    task automatic test_throughput();
        int cur_ph;
        int seen;
        logic [17:0] exp_v;
        seen      = 0;
        cur_ph    = int'($urandom_range(255));
        phase     = 8'(cur_ph);
        amplitude = 8'd190;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (out_valid === 1'b1) begin
                seen++;
                exp_v = model(cur_ph, 190);
                checks++;
                if ({cos_mag, cos_neg, sin_mag, sin_neg} !== exp_v) begin
                    errors++;
                    $display("FAIL stream ph=%0d: got %h required %h",
                             cur_ph, {cos_mag, cos_neg, sin_mag, sin_neg}, exp_v);
                end
                cur_ph = int'($urandom_range(255));
                phase  = 8'(cur_ph);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (seen != 10) begin
            errors++;
            $display("FAIL throughput: results in 50 cycles=%0d required 10", seen);
        end
    endtask

    task automatic test_sweep();
        int lat;
        int amp;
        logic [17:0] exp_v;
        for (int p = 0; p < 296; p++) begin
            amp = (p < 256) ? 255 : ((p % 8 == 0) ? 0 : int'($urandom_range(255)));
            issue(p % 256, amp, lat);
            exp_v = model(p % 256, amp);
            checks++;
            if (lat >= 20 || {cos_mag, cos_neg, sin_mag, sin_neg} !== exp_v) begin
                errors++;
                $display("FAIL sweep ph=%0d amp=%0d: lat=%0d got %h required %h",
                         p % 256, amp, lat, {cos_mag, cos_neg, sin_mag, sin_neg}, exp_v);
            end
            release_out();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        phase     = 8'd32;
        amplitude = 8'd255;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready, cos_mag, cos_neg, sin_mag, sin_neg} !== 20'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h required 0",
                     {out_valid, in_ready, cos_mag, cos_neg, sin_mag, sin_neg});
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL aborted_valid cycle %0d: out_valid=%b required 0", c, out_valid);
            end
        end
        issue(235, 255, lat);
        checks++;
        if (lat != 3 || {cos_mag, cos_neg, sin_mag, sin_neg} !== {8'd221, 1'b0, 8'd125, 1'b1}) begin
            errors++;
            $display("FAIL after_reset: lat=%0d cm=%0d cn=%b sm=%0d sn=%b required 3 221 0 125 1",
                     lat, cos_mag, cos_neg, sin_mag, sin_neg);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_throughput();
        test_sweep();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
